// File: rtl/test_channel_regbank_pkg.sv
// Shared constants and types for the multi-channel gate test register bank.
package test_channel_regbank_pkg;

  localparam logic [7:0] AddrId     = 8'h00;
  localparam logic [7:0] AddrCtrl   = 8'h01;
  localparam logic [7:0] AddrStatus = 8'h02;
  localparam logic [7:0] ChBase     = 8'h08;
  localparam logic [7:0] ChStride   = 8'h08;

  localparam logic [2:0] OffControl = 3'd0;
  localparam logic [2:0] OffInput   = 3'd1;
  localparam logic [2:0] OffOutput  = 3'd2;
  localparam logic [2:0] OffResult  = 3'd3;
  localparam logic [2:0] OffExpect  = 3'd4;

  localparam logic [31:0] RegbankId = 32'h504F4C49;
  localparam logic [31:0] BadRead   = 32'hBAD2BAD2;

  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlAbortBit  = 1;
  localparam int unsigned CtrlIrqEnBit  = 2;
  localparam int unsigned StDoneBit     = 1;
  localparam int unsigned StErrBit      = 2;
  localparam int unsigned StMismatchBit = 3;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StCapture,
    StDone
  } sweep_state_e;

endpackage

// File: rtl/test_channel_regbank_sweep_seq.sv
// Truth-table sweep sequencer: walks combos 0..3, holding each for a settle window before capture.
module test_channel_regbank_sweep_seq
  import test_channel_regbank_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       sweep_a,
  output logic       sweep_b,
  output logic       capture,
  output logic [1:0] combo,
  output logic       done_pulse
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  sweep_state_e    state_q, state_d;
  logic [1:0]      combo_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StApply;
      StApply:   state_d = abort ? StIdle : StSettle;
      StSettle: begin
        if (abort) state_d = StIdle;
        else if (cnt_q == '0) state_d = StCapture;
      end
      StCapture: begin
        if (abort) state_d = StIdle;
        else if (combo_q == 2'd3) state_d = StDone;
        else state_d = StApply;
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Settle counter is reloaded in APPLY so SETTLE lasts exactly SETTLE_CYCLES clocks.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      combo_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      if (state_q == StIdle && start) combo_q <= 2'd0;
      else if (state_q == StCapture && !abort && combo_q != 2'd3) combo_q <= combo_q + 2'd1;
      if (state_q == StApply) cnt_q <= CntLoad;
      else if (state_q == StSettle && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    busy       = (state_q == StApply) || (state_q == StSettle) || (state_q == StCapture);
    sweep_a    = combo_q[0];
    sweep_b    = combo_q[1];
    capture    = (state_q == StCapture) && !abort;
    combo      = combo_q;
    done_pulse = (state_q == StDone);
  end

endmodule

// File: rtl/test_channel_regbank.sv
// Register bank for NUM_CH two-input gate test channels with sweep sequencer and W1C status.
// Optional per-channel EXPECT compare is enabled by defining REGBANK_EXPECT_CHECK_EN.
module test_channel_regbank
  import test_channel_regbank_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [7:0]        register_select,
  input  logic              write_enable,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic [NUM_CH-1:0] ch_orient,
  output logic [NUM_CH-1:0] ch_a,
  output logic [NUM_CH-1:0] ch_b,
  input  logic [NUM_CH-1:0] ch_out,
  output logic              busy,
  output logic              done_irq
);

  localparam int unsigned ChShift = $clog2(ChStride);

  logic [NUM_CH-1:0] orient_q, a_q, b_q;
  logic [3:0]        result_q [NUM_CH];
  logic              irq_en_q, done_q, err_q, mismatch_rd;

  logic [7:0]        ch_rel, ch_idx;
  logic [2:0]        ch_off;
  logic              addr_ok, addr_ro, input_hit, wr_ctrl, wr_status, wr_err;
  logic [NUM_CH-1:0] wr_control, wr_input;
  logic              start, abort, sweep_a, sweep_b, capture, done_pulse;
  logic [1:0]        combo;
  logic              unused_wdata;

`ifdef REGBANK_EXPECT_CHECK_EN
  logic [3:0]        expect_q [NUM_CH];
  logic [NUM_CH-1:0] wr_expect;
  logic              mismatch_q, mismatch_any;
`endif

  assign ch_rel = register_select - ChBase;
  assign ch_idx = ch_rel >> ChShift;
  assign ch_off = ch_rel[2:0];

  // Decode and read mux share one pass so every address has a single notion of "mapped".
  always_comb begin
    read_data  = BadRead;
    addr_ok    = 1'b0;
    addr_ro    = 1'b0;
    input_hit  = 1'b0;
    wr_ctrl    = 1'b0;
    wr_status  = 1'b0;
    wr_control = '0;
    wr_input   = '0;
`ifdef REGBANK_EXPECT_CHECK_EN
    wr_expect  = '0;
`endif
    if (register_select == AddrId) begin
      read_data = RegbankId;
      addr_ok   = 1'b1;
      addr_ro   = 1'b1;
    end else if (register_select == AddrCtrl) begin
      read_data = {29'd0, irq_en_q, 2'b00};
      addr_ok   = 1'b1;
      wr_ctrl   = write_enable;
    end else if (register_select == AddrStatus) begin
      read_data = {28'd0, mismatch_rd, err_q, done_q, busy};
      addr_ok   = 1'b1;
      wr_status = write_enable;
    end else if (register_select >= ChBase) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == 8'(i)) begin
          case (ch_off)
            OffControl: begin
              read_data     = {31'd0, orient_q[i]};
              addr_ok       = 1'b1;
              wr_control[i] = write_enable;
            end
            OffInput: begin
              read_data   = {30'd0, b_q[i], a_q[i]};
              addr_ok     = 1'b1;
              input_hit   = 1'b1;
              wr_input[i] = write_enable && !busy;
            end
            OffOutput: begin
              read_data = {31'd0, ch_out[i]};
              addr_ok   = 1'b1;
              addr_ro   = 1'b1;
            end
            OffResult: begin
              read_data = {28'd0, result_q[i]};
              addr_ok   = 1'b1;
              addr_ro   = 1'b1;
            end
`ifdef REGBANK_EXPECT_CHECK_EN
            OffExpect: begin
              read_data    = {28'd0, expect_q[i]};
              addr_ok      = 1'b1;
              wr_expect[i] = write_enable;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign wr_err = write_enable && (!addr_ok || addr_ro || (input_hit && busy));
  assign abort  = wr_ctrl && write_data[CtrlAbortBit];
  assign start  = wr_ctrl && write_data[CtrlStartBit] && !write_data[CtrlAbortBit];

  test_channel_regbank_sweep_seq #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_seq (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .sweep_a   (sweep_a),
    .sweep_b   (sweep_b),
    .capture   (capture),
    .combo     (combo),
    .done_pulse(done_pulse)
  );

  // Sticky flags: a set on the same edge as a W1C wins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      orient_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
    end else begin
      if (wr_ctrl) irq_en_q <= write_data[CtrlIrqEnBit];
      done_q <= done_pulse || (done_q && !(wr_status && write_data[StDoneBit]));
      err_q  <= wr_err || (err_q && !(wr_status && write_data[StErrBit]));
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_control[i]) orient_q[i] <= write_data[0];
        if (wr_input[i]) begin
          a_q[i] <= write_data[0];
          b_q[i] <= write_data[1];
        end
        if (capture) result_q[i][combo] <= ch_out[i];
      end
    end
  end

`ifdef REGBANK_EXPECT_CHECK_EN
  always_comb begin
    mismatch_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (result_q[i] != expect_q[i]) mismatch_any = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mismatch_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) expect_q[i] <= '0;
    end else begin
      mismatch_q <= (done_pulse && mismatch_any)
                    || (mismatch_q && !(wr_status && write_data[StMismatchBit]));
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_expect[i]) expect_q[i] <= write_data[3:0];
      end
    end
  end

  assign mismatch_rd  = mismatch_q;
  assign done_irq     = irq_en_q && (done_q || mismatch_q);
  assign unused_wdata = ^write_data[31:4];
`else
  assign mismatch_rd  = 1'b0;
  assign done_irq     = irq_en_q && done_q;
  assign unused_wdata = ^write_data[31:3];
`endif

  // The sequencer owns a/b only while busy; INPUT registers reappear once it lets go.
  assign ch_orient = orient_q;
  assign ch_a      = busy ? {NUM_CH{sweep_a}} : a_q;
  assign ch_b      = busy ? {NUM_CH{sweep_b}} : b_q;

endmodule

// File: tb/tb_test_channel_regbank.sv
// Self-checking bench for test_channel_regbank: read scoreboard plus sweep timing/override checks.
module tb_test_channel_regbank;

  localparam int unsigned NumCh    = 4;
  localparam int unsigned Settle   = 4;
  localparam int unsigned SweepLen = 4 * (Settle + 2);
  localparam logic [31:0] Mask     = (32'd1 << NumCh) - 32'd1;
  localparam logic [31:0] Bad      = 32'hBAD2BAD2;
  localparam logic [31:0] Id       = 32'h504F4C49;

  logic             CLK;
  logic             nRST;
  logic [7:0]       register_select;
  logic             write_enable;
  logic [31:0]      write_data;
  logic [31:0]      read_data;
  logic [NumCh-1:0] ch_orient, ch_a, ch_b, ch_out;
  logic             busy, done_irq;

  int          checks;
  int          errors;
  int          mode;
  int          n;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  test_channel_regbank #(
    .NUM_CH       (NumCh),
    .SETTLE_CYCLES(Settle)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .register_select(register_select),
    .write_enable   (write_enable),
    .write_data     (write_data),
    .read_data      (read_data),
    .ch_orient      (ch_orient),
    .ch_a           (ch_a),
    .ch_b           (ch_b),
    .ch_out         (ch_out),
    .busy           (busy),
    .done_irq       (done_irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Structure model: mode 0 is NAND; mode 1 is XOR, inverted on odd channels.
  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      ch_out[i] = (mode == 0) ? ~(ch_a[i] & ch_b[i]) : (ch_a[i] ^ ch_b[i] ^ (i % 2 == 1));
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    register_select = addr;
    write_enable    = 1'b0;
    #1;
    check_eq(tag_q.pop_front(), read_data, exp_q.pop_front());
    @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    register_select = addr;
    write_data      = data;
    write_enable    = 1'b1;
    @(negedge CLK);
    write_enable    = 1'b0;
  endtask

  // Starts a sweep and checks the sequencer drive every busy cycle; returns in the DONE cycle.
  task automatic sweep(input int poke_at, input logic [7:0] poke_addr, input logic [31:0] poke_data,
                       output int cycles);
    logic [1:0] c;
    wr(8'h01, 32'h5);
    cycles = 0;
    while (busy && cycles < 100) begin
      c = 2'(cycles / (Settle + 2));
      check_eq("sweep_a", 32'(ch_a), c[0] ? Mask : 32'h0);
      check_eq("sweep_b", 32'(ch_b), c[1] ? Mask : 32'h0);
      cycles++;
      if (cycles - 1 == poke_at) wr(poke_addr, poke_data);
      else @(negedge CLK);
    end
    check_eq("busy_len", 32'(cycles), 32'(SweepLen));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    mode = 0;
    nRST = 1'b0;
    register_select = 8'h00;
    write_enable = 1'b0;
    write_data = 32'h0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Reset state and read decode boundaries
    rd(8'h00, Id, "id");
    rd(8'h02, 32'h0, "status_rst");
    rd(8'h0B, 32'h0, "result0_rst");
    rd(8'h01, 32'h0, "ctrl_rst");
    check_eq("orient_rst", 32'(ch_orient), 32'h0);
    check_eq("a_rst", 32'(ch_a), 32'h0);
    check_eq("b_rst", 32'(ch_b), 32'h0);
    check_eq("irq_rst", 32'(done_irq), 32'h0);
    rd(8'h03, Bad, "glob_unmapped");
    rd(8'h28, Bad, "ch_oob");
    rd(8'h0F, Bad, "ch_gap");

    // Register-driven outputs
    wr(8'h09, 32'h3);
    wr(8'h08, 32'h1);
    check_eq("a_reg", 32'(ch_a), 32'h1);
    check_eq("b_reg", 32'(ch_b), 32'h1);
    check_eq("orient_reg", 32'(ch_orient), 32'h1);
    rd(8'h09, 32'h3, "input0");
    rd(8'h08, 32'h1, "control0");
    wr(8'h19, 32'h2);
    rd(8'h19, 32'h2, "input2");
    check_eq("b_reg2", 32'(ch_b), 32'h5);
    rd(8'h0A, 32'h0, "output0_live");
    rd(8'h12, 32'h1, "output1_live");

    // Full NAND sweep
    sweep(-1, 8'h00, 32'h0, n);
    check_eq("a_restored", 32'(ch_a), 32'h1);
    check_eq("b_restored", 32'(ch_b), 32'h5);
    check_eq("orient_kept", 32'(ch_orient), 32'h1);
    @(negedge CLK);
    check_eq("irq_done", 32'(done_irq), 32'h1);
    rd(8'h02, 32'h2, "status_done");
    rd(8'h01, 32'h4, "ctrl_irq_en");
    for (int ch = 0; ch < NumCh; ch++) rd(8'(8'h0B + 8 * ch), 32'h7, "result_nand");
    rd(8'h09, 32'h3, "input0_kept");
    wr(8'h02, 32'h2);
    check_eq("irq_clr", 32'(done_irq), 32'h0);
    rd(8'h02, 32'h0, "status_clr");

    // Start and abort together while idle: nothing happens
    wr(8'h01, 32'h7);
    check_eq("start_abort_idle", 32'(busy), 32'h0);
    rd(8'h02, 32'h0, "status_sa_idle");

    // Abort in SETTLE of combo 1: only combo 0 captured
    mode = 1;
    wr(8'h01, 32'h5);
    repeat (8) @(negedge CLK);
    wr(8'h01, 32'h6);
    check_eq("abort_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge CLK);
    check_eq("abort_irq", 32'(done_irq), 32'h0);
    rd(8'h02, 32'h0, "abort_status");
    for (int ch = 0; ch < NumCh; ch++)
      rd(8'(8'h0B + 8 * ch), (ch % 2 == 1) ? 32'h7 : 32'h6, "result_partial");

    // Full sweep with an ignored restart mid-way
    sweep(3, 8'h01, 32'h5, n);
    @(negedge CLK);
    rd(8'h02, 32'h2, "status_restart_ignored");
    for (int ch = 0; ch < NumCh; ch++)
      rd(8'(8'h0B + 8 * ch), (ch % 2 == 1) ? 32'h9 : 32'h6, "result_xor");
    wr(8'h02, 32'h2);

    // Write errors
    wr(8'h0A, 32'h1);
    rd(8'h02, 32'h4, "err_ro_output");
    rd(8'h08, 32'h1, "control0_unchanged");
    wr(8'h02, 32'h4);
    rd(8'h02, 32'h0, "err_clr");
    wr(8'h50, 32'hFFFF);
    rd(8'h02, 32'h4, "err_unmapped");
    wr(8'h02, 32'h4);
    wr(8'h0B, 32'h0);
    rd(8'h02, 32'h4, "err_ro_result");
    rd(8'h0B, 32'h6, "result_unchanged");
    wr(8'h02, 32'h4);
    wr(8'h00, 32'h0);
    rd(8'h02, 32'h4, "err_ro_id");
    rd(8'h00, Id, "id_unchanged");
    wr(8'h02, 32'h4);

    // INPUT write while busy, and W1C of done on the edge it is set
    sweep(2, 8'h09, 32'h0, n);
    wr(8'h02, 32'h2);
    rd(8'h02, 32'h6, "status_setwins_err");
    rd(8'h09, 32'h3, "input_busy_dropped");
    check_eq("a_after_drop", 32'(ch_a), 32'h1);
    wr(8'h02, 32'h6);
    rd(8'h02, 32'h0, "status_clr2");

`ifdef REGBANK_EXPECT_CHECK_EN
    rd(8'h0C, 32'h0, "expect_rst");
    wr(8'h0C, 32'h7);
    wr(8'h14, 32'h8);
    rd(8'h0C, 32'h7, "expect0");
    rd(8'h14, 32'h8, "expect1");
    mode = 0;
    sweep(-1, 8'h00, 32'h0, n);
    @(negedge CLK);
    rd(8'h02, 32'hA, "status_mismatch");
    check_eq("irq_mismatch", 32'(done_irq), 32'h1);
    wr(8'h02, 32'h2);
    rd(8'h02, 32'h8, "status_mismatch_only");
    check_eq("irq_mismatch_only", 32'(done_irq), 32'h1);
    wr(8'h02, 32'h8);
    check_eq("irq_mm_clr", 32'(done_irq), 32'h0);
    for (int ch = 0; ch < NumCh; ch++) wr(8'(8'h0C + 8 * ch), 32'h7);
    sweep(-1, 8'h00, 32'h0, n);
    @(negedge CLK);
    rd(8'h02, 32'h2, "status_match");
    wr(8'h02, 32'h2);
`else
    rd(8'h0C, Bad, "expect_absent");
    wr(8'h0C, 32'h7);
    rd(8'h02, 32'h4, "err_expect_absent");
    wr(8'h02, 32'h4);
`endif

    // Reset mid-sweep
    mode = 0;
    wr(8'h01, 32'h5);
    repeat (10) @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_eq("rst_mid_busy", 32'(busy), 32'h0);
    check_eq("rst_mid_a", 32'(ch_a), 32'h0);
    check_eq("rst_mid_orient", 32'(ch_orient), 32'h0);
    check_eq("rst_mid_irq", 32'(done_irq), 32'h0);
    rd(8'h0B, 32'h0, "rst_mid_result");
    nRST = 1'b1;
    rd(8'h01, 32'h0, "rst_mid_ctrl");
    rd(8'h02, 32'h0, "rst_mid_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
